// File: rtl/serial_load_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_load_rx
// Brief    : Framed one-bit-per-clock serial receiver feeding a byte load register.
// Revision : 1.0 - initial release
// ============================================================================
module serial_load_rx #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1,
    parameter bit IDLE_LVL  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             en,
    input  logic             sin,
    output logic [WIDTH-1:0] data,
    output logic             load,
    output logic             frame_err,
    output logic             busy
);

    localparam int            c_cw   = $clog2(WIDTH) + 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_data = 2'd1;
    localparam logic [1:0] c_stop = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [c_cw-1:0]  r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_next;
    logic             w_start;
    logic             w_stop_ok;

    assign w_start   = (sin == ~IDLE_LVL);
    assign w_stop_ok = (sin == IDLE_LVL);

    // Bit ordering is fixed at elaboration time
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_shift_next = {sin, r_shift[WIDTH-1:1]};
        end else begin : g_msb_first
            assign w_shift_next = {r_shift[WIDTH-2:0], sin};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_state <= c_idle;
        end else if (en) begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (w_start) w_next_state = c_data;
            c_data:  if (r_cnt == c_last) w_next_state = c_stop;
            c_stop:  w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        if (r_state != c_idle) begin
            busy = 1'b1;
        end
    end

    // Strobes default low every edge; only an enabled STOP edge raises one
    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_cnt     <= '0;
            r_shift   <= '0;
            data      <= '0;
            load      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            load      <= 1'b0;
            frame_err <= 1'b0;
            if (en) begin
                case (r_state)
                    c_idle: begin
                        if (w_start) begin
                            r_cnt <= '0;
                        end
                    end
                    c_data: begin
                        r_shift <= w_shift_next;
                        r_cnt   <= r_cnt + c_cw'(1);
                    end
                    c_stop: begin
                        if (w_stop_ok) begin
                            data <= r_shift;
                            load <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
